// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types and constants for the MIPS core front end
package mips_cpu_pkg;
   typedef enum logic [1:0] {RUN, PENDING, HALTED} pc_state_t;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
   localparam int INSTR_BYTES = 4;
   localparam logic [31:0] HALT_ADDR = 32'h0;
endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with branch delay slot, exception redirect and halt-at-zero
module pc_sequencer
   import mips_cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT),
   parameter int INSTR_BYTES = mips_cpu_pkg::INSTR_BYTES,
   parameter logic [WIDTH-1:0] HALT_ADDR = WIDTH'(mips_cpu_pkg::HALT_ADDR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             stall,
   input  logic             branch_valid,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             exc_valid,
   input  logic [WIDTH-1:0] exc_target,
   output logic [WIDTH-1:0] pc,
   output logic             in_delay_slot,
   output logic             active,
   output logic             misaligned
);
   pc_state_t state;
   logic [WIDTH-1:0] target_q;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_next;
   logic advance;
   logic take_branch;
   logic halt_next;
   logic mis_next;
   // next-pc selection: exception first, then pending redirect, else sequential
   always_comb begin
      advance     = clk_enable && !stall && state != HALTED;
      pc_inc      = pc + WIDTH'(INSTR_BYTES);
      take_branch = state == RUN && branch_valid && !exc_valid;
      pc_next     = exc_valid ? exc_target : (state == PENDING) ? target_q : pc_inc;
      halt_next   = pc_next == HALT_ADDR;
      mis_next    = pc_next[1:0] != 2'b00;
   end
   // single registered update of pc, state and status outputs on each advance
   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= RESET_VECTOR;
         state         <= RUN;
         target_q      <= '0;
         in_delay_slot <= 1'b0;
         active        <= 1'b1;
         misaligned    <= 1'b0;
      end else if (advance) begin
         pc            <= pc_next;
         state         <= halt_next ? HALTED : take_branch ? PENDING : RUN;
         in_delay_slot <= take_branch && !halt_next;
         active        <= !halt_next;
         misaligned    <= exc_valid ? mis_next : (misaligned || mis_next);
         if (take_branch) target_q <= branch_target;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector self-checking bench for pc_sequencer
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clk_enable = 1'b0;
   logic stall = 1'b0;
   logic branch_valid = 1'b0;
   logic [31:0] branch_target = '0;
   logic exc_valid = 1'b0;
   logic [31:0] exc_target = '0;
   logic [31:0] pc;
   logic in_delay_slot, active, misaligned;
   int total = 0;
   int bad = 0;

   pc_sequencer dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .exc_valid(exc_valid), .exc_target(exc_target),
      .pc(pc), .in_delay_slot(in_delay_slot), .active(active), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_ds);
      chk({tag, ".pc"}, pc, exp_pc);
      chk({tag, ".ds"}, {31'b0, in_delay_slot}, {31'b0, exp_ds});
   endtask

   initial begin
      step();
      reset = 1'b0;
      chk_pc("reset", 32'hBFC00000, 1'b0);
      chk("reset.active", {31'b0, active}, 32'd1);
      chk("reset.mis", {31'b0, misaligned}, 32'd0);
      step();
      chk_pc("frozen_noenable", 32'hBFC00000, 1'b0);
      clk_enable = 1'b1;
      step(); chk_pc("seq1", 32'hBFC00004, 1'b0);
      step(); chk_pc("seq2", 32'hBFC00008, 1'b0);
      step(); chk_pc("seq3", 32'hBFC0000C, 1'b0);
      chk("seq.active", {31'b0, active}, 32'd1);
      step(); chk_pc("seq4", 32'hBFC00010, 1'b0);
      branch_valid = 1'b1; branch_target = 32'hBFC00100;
      step(); chk_pc("br.slot", 32'hBFC00014, 1'b1);
      branch_valid = 1'b0;
      step(); chk_pc("br.tgt", 32'hBFC00100, 1'b0);
      branch_valid = 1'b1; branch_target = 32'hBFC00200;
      step(); chk_pc("stl.slot", 32'hBFC00104, 1'b1);
      branch_valid = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_pc("stl.hold", 32'hBFC00104, 1'b1);
      end
      stall = 1'b0; clk_enable = 1'b0;
      step(); chk_pc("en.hold", 32'hBFC00104, 1'b1);
      clk_enable = 1'b1;
      step(); chk_pc("stl.tgt", 32'hBFC00200, 1'b0);
      exc_valid = 1'b1; exc_target = 32'hBFC00380;
      branch_valid = 1'b1; branch_target = 32'hBFC00500;
      step(); chk_pc("excbr", 32'hBFC00380, 1'b0);
      exc_valid = 1'b0; branch_valid = 1'b0;
      step(); chk_pc("excbr.next", 32'hBFC00384, 1'b0);
      branch_valid = 1'b1; branch_target = 32'hBFC00600;
      step(); chk_pc("excpend.slot", 32'hBFC00388, 1'b1);
      branch_valid = 1'b0; exc_valid = 1'b1;
      step(); chk_pc("excpend", 32'hBFC00380, 1'b0);
      exc_valid = 1'b0;
      step(); chk_pc("excpend.drop", 32'hBFC00384, 1'b0);
      branch_valid = 1'b1; branch_target = 32'hBFC00102;
      step(); chk_pc("mis.slot", 32'hBFC00388, 1'b1);
      chk("mis.before", {31'b0, misaligned}, 32'd0);
      branch_valid = 1'b0;
      step(); chk_pc("mis.tgt", 32'hBFC00102, 1'b0);
      chk("mis.set", {31'b0, misaligned}, 32'd1);
      step(); chk_pc("mis.seq", 32'hBFC00106, 1'b0);
      chk("mis.sticky", {31'b0, misaligned}, 32'd1);
      exc_valid = 1'b1;
      step(); chk_pc("mis.exc", 32'hBFC00380, 1'b0);
      chk("mis.clear", {31'b0, misaligned}, 32'd0);
      exc_valid = 1'b0; branch_valid = 1'b1; branch_target = 32'hBFC00700;
      step(); chk_pc("rstpend.slot", 32'hBFC00384, 1'b1);
      branch_valid = 1'b0; reset = 1'b1;
      step(); chk_pc("rstpend.rst", 32'hBFC00000, 1'b0);
      reset = 1'b0;
      step(); chk_pc("rstpend.n1", 32'hBFC00004, 1'b0);
      step(); chk_pc("rstpend.n2", 32'hBFC00008, 1'b0);
      branch_valid = 1'b1; branch_target = 32'h0;
      step(); chk_pc("halt.slot", 32'hBFC0000C, 1'b1);
      chk("halt.slot.active", {31'b0, active}, 32'd1);
      branch_valid = 1'b0;
      step(); chk_pc("halt.pc", 32'h0, 1'b0);
      chk("halt.active", {31'b0, active}, 32'd0);
      branch_valid = 1'b1; branch_target = 32'hBFC00100;
      exc_valid = 1'b1; exc_target = 32'hBFC00380;
      step(); step();
      chk_pc("halt.absorb", 32'h0, 1'b0);
      chk("halt.absorb.active", {31'b0, active}, 32'd0);
      branch_valid = 1'b0; exc_valid = 1'b0; reset = 1'b1;
      step(); reset = 1'b0;
      chk_pc("halt.rst", 32'hBFC00000, 1'b0);
      chk("halt.rst.active", {31'b0, active}, 32'd1);
      exc_valid = 1'b1; exc_target = 32'h0;
      step(); chk_pc("exchalt", 32'h0, 1'b0);
      chk("exchalt.active", {31'b0, active}, 32'd0);
      exc_valid = 1'b0; reset = 1'b1;
      step(); reset = 1'b0;
      exc_valid = 1'b1; exc_target = 32'hFFFFFFF8;
      step(); chk_pc("wrap.a", 32'hFFFFFFF8, 1'b0);
      exc_valid = 1'b0;
      step(); chk_pc("wrap.b", 32'hFFFFFFFC, 1'b0);
      chk("wrap.b.active", {31'b0, active}, 32'd1);
      step(); chk_pc("wrap.c", 32'h0, 1'b0);
      chk("wrap.c.active", {31'b0, active}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
